// File: rtl/fwd_hazard_ctrl.sv
// Execute-stage operand forwarding and load-use hazard controller.
// Tracks EX/MEM/WB destination info and emits registered operand selects.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } stage_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    stage_t           exRec_q, memRec_q, wbRec_q;
    stage_t           exRec_d;
    logic [1:0]       selA_q, selB_q, selA_d, selB_d;
    logic [CNT_W-1:0] stallCnt_q, fwdCnt_q;
    logic             loadUse;
    logic             stallInt;
    logic             accept;
    logic             fwdHit;
    logic             unusedBits;

    function automatic logic produces(input stage_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != '0);
    endfunction

    // Youngest producer wins; a load in EX cannot forward and is handled by the stall.
    function automatic logic [1:0] nextSel(input logic useRs, input logic [REG_ADDR_W-1:0] rs,
                                           input stage_t ex, input stage_t mem);
        if (!useRs)
            return SEL_RF;
        else if (produces(ex, rs) && !ex.memread)
            return SEL_MEM;
        else if (produces(mem, rs))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        loadUse = exRec_q.valid && exRec_q.memread && exRec_q.regwrite && (exRec_q.rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == exRec_q.rd)) ||
                   (id_use_rs2 && (id_rs2 == exRec_q.rd)));
        stallInt = id_valid && !flush && loadUse;
        accept   = !flush && !stallInt;

        exRec_d          = '0;
        exRec_d.valid    = id_valid;
        exRec_d.rd       = id_rd;
        exRec_d.regwrite = id_regwrite && id_valid;
        exRec_d.memread  = id_memread && id_valid;

        selA_d = id_valid ? nextSel(id_use_rs1, id_rs1, exRec_q, memRec_q) : SEL_RF;
        selB_d = id_valid ? nextSel(id_use_rs2, id_rs2, exRec_q, memRec_q) : SEL_RF;
        fwdHit = accept && id_valid && ((selA_d != SEL_RF) || (selB_d != SEL_RF));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exRec_q    <= '0;
            memRec_q   <= '0;
            wbRec_q    <= '0;
            selA_q     <= SEL_RF;
            selB_q     <= SEL_RF;
            stallCnt_q <= '0;
            fwdCnt_q   <= '0;
        end else begin
            memRec_q <= exRec_q;
            wbRec_q  <= memRec_q;
            if (accept) begin
                exRec_q <= exRec_d;
                selA_q  <= selA_d;
                selB_q  <= selB_d;
            end else begin
                exRec_q <= '0;
                selA_q  <= SEL_RF;
                selB_q  <= SEL_RF;
            end
            if (stallInt && (stallCnt_q != '1))
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            if (fwdHit && (fwdCnt_q != '1))
                fwdCnt_q <= fwdCnt_q + CNT_W'(1);
        end
    end

    // WB producers are served by the regfile bypass, so the WB record is kept only for visibility.
    assign unusedBits = ^{memRec_q.memread, wbRec_q};

    assign sel_a     = selA_q;
    assign sel_b     = selB_q;
    assign stall     = stallInt;
    assign ex_valid  = exRec_q.valid;
    assign stall_cnt = stallCnt_q;
    assign fwd_cnt   = fwdCnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a queue of expected selects is drained by
// a monitor each time an instruction occupies EX; stall and counters are checked per cycle.
module tb_fwd_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_regwrite = 1'b0, id_memread = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    sel_a, sel_b;
    logic          stall, ex_valid;
    logic [CW-1:0] stall_cnt, fwd_cnt;

    int         total = 0;
    int         bad = 0;
    int         vecNum = 0;
    int         expStallCnt = 0;
    int         expFwdCnt = 0;
    logic       pendReset = 1'b1;
    logic       pendStall = 1'b0;
    logic       pendFwd = 1'b0;
    logic [3:0] selQueue[$];

    fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .ex_valid(ex_valid),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int satInc(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    // Drive one decode-stage vector and check the same-cycle stall, ex_valid and counters.
    task automatic applyStimulus(input logic v, input int rd, input int rs1, input int rs2,
                                 input logic u1, input logic u2, input logic rw, input logic mr,
                                 input logic fl, input logic rst, input logic eStall,
                                 input logic eEx, input logic [1:0] eA, input logic [1:0] eB);
        logic acc;
        @(posedge clk);
        #1;
        if (pendReset) begin
            expStallCnt = 0;
            expFwdCnt   = 0;
        end else begin
            if (pendStall) expStallCnt = satInc(expStallCnt);
            if (pendFwd)   expFwdCnt   = satInc(expFwdCnt);
        end
        id_valid    = v;
        id_rd       = RW'(rd);
        id_rs1      = RW'(rs1);
        id_rs2      = RW'(rs2);
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        reset       = rst;
        @(negedge clk);
        vecNum++;
        checkOutput($sformatf("stall@v%0d", vecNum), 32'(stall), 32'(eStall));
        checkOutput($sformatf("ex_valid@v%0d", vecNum), 32'(ex_valid), 32'(eEx));
        checkOutput($sformatf("stall_cnt@v%0d", vecNum), 32'(stall_cnt), 32'(expStallCnt));
        checkOutput($sformatf("fwd_cnt@v%0d", vecNum), 32'(fwd_cnt), 32'(expFwdCnt));
        acc       = v && !fl && !eStall && !rst;
        pendReset = rst;
        pendStall = eStall && !rst;
        pendFwd   = acc && ((eA != 2'b00) || (eB != 2'b00));
        if (acc)
            selQueue.push_back({eA, eB});
    endtask

    task automatic idle(input logic eEx);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eEx, 2'b00, 2'b00);
    endtask

    // Monitor: every cycle an instruction sits in EX its selects must match the oldest entry.
    initial begin
        logic [3:0] expSel;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (ex_valid) begin
                if (selQueue.size() == 0) begin
                    checkOutput("sb_unexpected_ex", 32'(ex_valid), 32'd0);
                end else begin
                    expSel = selQueue.pop_front();
                    checkOutput("sel_a", 32'(sel_a), 32'(expSel[3:2]));
                    checkOutput("sel_b", 32'(sel_b), 32'(expSel[1:0]));
                end
            end else begin
                checkOutput("bubble_sel", 32'({sel_a, sel_b}), 32'd0);
            end
        end
    end

    initial begin
        $display("[TB] start");
        // reset two cycles, then idle five
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) idle(0);

        // back-to-back ALU dependency: add x5; sub x6 = x5 - x1
        applyStimulus(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b00);
        idle(1);

        // two-apart: add x5, nop, or x7 = x5 | x5
        applyStimulus(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(1);
        applyStimulus(1, 7, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01);
        // same with an intervening add x5: youngest wins
        applyStimulus(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 5, 3, 4, 1, 1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 7, 5, 5, 1, 1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10);

        // load-use: lw x8; add x9 = x2 + x8 stalls once then gets 01
        applyStimulus(1, 8, 2, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 9, 2, 8, 1, 1, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00);
        applyStimulus(1, 9, 2, 8, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01);
        idle(1);

        // x0 never forwards or stalls
        applyStimulus(1, 0, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 10, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 11, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00);

        // unused rs2 matching a pending load rd
        applyStimulus(1, 12, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 13, 1, 12, 1, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00);

        // flush while a load-use stall is pending
        applyStimulus(1, 14, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00);
        applyStimulus(1, 15, 14, 14, 1, 1, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00);
        idle(0);

        // reset during a load-use stall clears every record
        applyStimulus(1, 16, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 17, 16, 1, 1, 1, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00);
        applyStimulus(1, 17, 16, 1, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(1);

        // repeated load-use pairs drive both counters into saturation
        for (int i = 0; i < CMAX + 2; i++) begin
            applyStimulus(1, 8, 2, 0, 1, 0, 1, 1, 0, 0, 0, (i == 0) ? 1'b0 : 1'b1, 2'b00, 2'b00);
            applyStimulus(1, 9, 2, 8, 1, 1, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00);
            applyStimulus(1, 9, 2, 8, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01);
        end
        idle(1);
        idle(0);
        idle(0);

        checkOutput("sb_drain", 32'(selQueue.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
